// File: rtl/perf_counters_pkg.sv
// Shared definitions for the performance-counter peripheral: register offsets,
// the address field that carries them, and the command encoding.
package perf_counters_pkg;

  localparam int PERF_HIBIT = 6;
  localparam int PERF_LOBIT = 3;
  localparam int PERF_OFF_W = PERF_HIBIT - PERF_LOBIT + 1;

  typedef logic [PERF_OFF_W-1:0] perf_off_t;

  localparam perf_off_t OFF_CLEAR = 4'd0;
  localparam perf_off_t OFF_START = 4'd1;
  localparam perf_off_t OFF_STOP  = 4'd2;
  localparam perf_off_t OFF_CYCLE = 4'd3;
  localparam perf_off_t OFF_STALL = 4'd4;
  localparam perf_off_t OFF_IMISS = 4'd5;
  localparam perf_off_t OFF_DMISS = 4'd6;

  typedef enum logic [1:0] {
    CMD_CLEAR    = 2'd0,
    CMD_START    = 2'd1,
    CMD_STOP     = 2'd2,
    CMD_SNAPSHOT = 2'd3
  } cmd_op_e;

  // Register offsets live in address bits [PERF_HIBIT:PERF_LOBIT].
  function automatic logic [31:0] perf_addr(input logic [31:0] base, input perf_off_t off);
    logic [31:0] field;
    field = '0;
    field[PERF_HIBIT:PERF_LOBIT] = off;
    return base + field;
  endfunction

endpackage

// File: rtl/perf_counters_reader.sv
// Bus master that issues clear/start/stop writes to the performance-counter
// peripheral and gathers the four counters into a snapshot on request.
//
// state    | meaning
// IDLE     | ready for a command
// REQ      | request on the bus, waiting for grant
// WAIT_RSP | snapshot read granted, waiting for matching response
// DONE     | snapshot published, returning to IDLE
module perf_counters_reader
  import perf_counters_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned PER_ID_WIDTH = 17,
  parameter int unsigned MY_ID        = 0,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  input  logic [1:0]              cmd_op_i,
  output logic                    cmd_ready_o,
  output logic                    req_o,
  output logic [31:0]             add_o,
  output logic                    wen_o,
  output logic [31:0]             wdata_o,
  output logic [3:0]              be_o,
  output logic [PER_ID_WIDTH-1:0] id_o,
  input  logic                    gnt_i,
  input  logic                    r_valid_i,
  input  logic [31:0]             r_rdata_i,
  input  logic [PER_ID_WIDTH-1:0] r_id_i,
  output logic [31:0]             snap_cycle_o,
  output logic [31:0]             snap_stall_o,
  output logic [31:0]             snap_imiss_o,
  output logic [31:0]             snap_dmiss_o,
  output logic                    snap_valid_o,
  output logic                    err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_e;

  localparam logic [PER_ID_WIDTH-1:0] OWN_ID   = PER_ID_WIDTH'(MY_ID);
  localparam logic [6:0]              TMO_LAST = 7'(TIMEOUT - 1);

  state_e            state_q, state_d;
  cmd_op_e           op_q, op_d;
  logic [1:0]        idx_q, idx_d;
  logic [6:0]        tmo_q, tmo_d;
  logic              req_q, req_d;
  logic              wen_q, wen_d;
  logic [31:0]       add_q, add_d;
  logic [3:0][31:0]  stage_q, stage_d;
  logic [3:0][31:0]  snap_q, snap_d;
  logic              snap_valid_q, snap_valid_d;
  logic              err_q, err_d;
  logic              rsp_hit;

  assign rsp_hit = r_valid_i && (r_id_i == OWN_ID);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    req_d        = req_q;
    wen_d        = wen_q;
    add_d        = add_q;
    stage_d      = stage_q;
    snap_d       = snap_q;
    snap_valid_d = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          op_d    = cmd_op_e'(cmd_op_i);
          idx_d   = 2'd0;
          req_d   = 1'b1;
          state_d = REQ;
          if (cmd_op_i == CMD_SNAPSHOT) begin
            wen_d = 1'b1;
            add_d = perf_addr(BASE_ADDR, OFF_CYCLE);
          end else begin
            // Clear/start/stop offsets coincide with their op encodings.
            wen_d = 1'b0;
            add_d = perf_addr(BASE_ADDR, perf_off_t'(cmd_op_i));
          end
        end
      end
      REQ: begin
        if (gnt_i) begin
          req_d = 1'b0;
          if (op_q == CMD_SNAPSHOT) begin
            tmo_d   = 7'd0;
            state_d = WAIT_RSP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT_RSP: begin
        if (rsp_hit) begin
          stage_d[idx_q] = r_rdata_i;
          if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            req_d   = 1'b1;
            add_d   = perf_addr(BASE_ADDR, OFF_CYCLE + {2'b00, idx_q + 2'd1});
            state_d = REQ;
          end else begin
            // Publish together with the pulse so the outputs are valid in DONE.
            snap_d       = stage_d;
            snap_valid_d = 1'b1;
            state_d      = DONE;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          idx_d   = 2'd0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 7'd1;
        end
      end
      DONE: begin
        idx_d   = 2'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      op_q         <= CMD_CLEAR;
      idx_q        <= 2'd0;
      tmo_q        <= 7'd0;
      req_q        <= 1'b0;
      wen_q        <= 1'b1;
      add_q        <= BASE_ADDR;
      stage_q      <= '0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      req_q        <= req_d;
      wen_q        <= wen_d;
      add_q        <= add_d;
      stage_q      <= stage_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      err_q        <= err_d;
    end
  end

  assign cmd_ready_o  = (state_q == IDLE);
  assign req_o        = req_q;
  assign add_o        = add_q;
  assign wen_o        = wen_q;
  assign wdata_o      = 32'h0;
  assign be_o         = 4'hF;
  assign id_o         = OWN_ID;
  assign snap_cycle_o = snap_q[0];
  assign snap_stall_o = snap_q[1];
  assign snap_imiss_o = snap_q[2];
  assign snap_dmiss_o = snap_q[3];
  assign snap_valid_o = snap_valid_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_perf_counters_reader.sv
// Randomized bench for perf_counters_reader: a behavioural slave answers the
// bus, expected transactions and results are queued and checked by a monitor.
module tb_perf_counters_reader;
  import perf_counters_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          IDW  = 17;
  localparam int          MYID = 5;
  localparam int          TMO  = 64;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            cmd_valid_i = 1'b0;
  logic [1:0]      cmd_op_i = 2'd0;
  logic            gnt_i = 1'b0;
  logic            r_valid_i = 1'b0;
  logic [31:0]     r_rdata_i = 32'h0;
  logic [IDW-1:0]  r_id_i = '0;
  logic            cmd_ready_o, req_o, wen_o, snap_valid_o, err_o;
  logic [31:0]     add_o, wdata_o, snap_cycle_o, snap_stall_o, snap_imiss_o, snap_dmiss_o;
  logic [3:0]      be_o;
  logic [IDW-1:0]  id_o;

  perf_counters_reader #(
    .BASE_ADDR(BASE), .PER_ID_WIDTH(IDW), .MY_ID(MYID), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_op_i(cmd_op_i),
    .cmd_ready_o(cmd_ready_o), .req_o(req_o), .add_o(add_o), .wen_o(wen_o),
    .wdata_o(wdata_o), .be_o(be_o), .id_o(id_o), .gnt_i(gnt_i),
    .r_valid_i(r_valid_i), .r_rdata_i(r_rdata_i), .r_id_i(r_id_i),
    .snap_cycle_o(snap_cycle_o), .snap_stall_o(snap_stall_o),
    .snap_imiss_o(snap_imiss_o), .snap_dmiss_o(snap_dmiss_o),
    .snap_valid_o(snap_valid_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; logic wen; } bus_t;
  typedef struct { bit is_err; logic [3:0][31:0] v; int lat; } res_t;

  bus_t             exp_bus[$];
  res_t             exp_res[$];
  logic [3:0][31:0] last_snap = '0;
  logic [31:0]      ctr_val [4];
  int  checks = 0, errors = 0;
  int  cyc = 0, t_acc = 0, t_drop_gnt = 0, n_reads = 0;
  bit  zero_wait = 1'b1, bad_id = 1'b0, bogus = 1'b0;
  int  stall_dly = -1, drop_idx = -1;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void note_fail(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected nothing (cycle %0d)", nm, act, cyc);
  endfunction

  // Monitor: bus requests against the expected transaction list, and
  // snapshot/error pulses against the expected outcome list.
  bit prev_req_open = 1'b0;
  always @(negedge clk_i) begin
    res_t r;
    if (!rst_ni) begin
      prev_req_open = 1'b0;
    end else begin
      if (prev_req_open) chk("req_held", 32'(req_o), 32'd1);
      if (req_o) begin
        if (exp_bus.size() == 0) begin
          note_fail("unexpected_req", add_o);
        end else begin
          chk("bus_add", add_o, exp_bus[0].addr);
          chk("bus_wen", 32'(wen_o), 32'(exp_bus[0].wen));
          if (gnt_i) begin
            chk("bus_wdata", wdata_o, 32'h0);
            chk("bus_be", 32'(be_o), 32'hF);
            chk("bus_id", 32'(id_o), 32'(MYID));
            void'(exp_bus.pop_front());
          end
        end
      end
      prev_req_open = req_o && !gnt_i;

      if (snap_valid_o || err_o) begin
        if (exp_res.size() == 0) begin
          note_fail("unexpected_result", {30'd0, snap_valid_o, err_o});
        end else begin
          r = exp_res.pop_front();
          chk("result_err", 32'(err_o), 32'(r.is_err));
          chk("result_snap_valid", 32'(snap_valid_o), 32'(!r.is_err));
          chk("snap_cycle", snap_cycle_o, r.v[0]);
          chk("snap_stall", snap_stall_o, r.v[1]);
          chk("snap_imiss", snap_imiss_o, r.v[2]);
          chk("snap_dmiss", snap_dmiss_o, r.v[3]);
          if (r.is_err) begin
            chk("err_back_idle", 32'(cmd_ready_o), 32'd1);
            chk("err_timing", 32'(cyc - t_drop_gnt), 32'(TMO));
          end else begin
            last_snap = r.v;
            if (r.lat >= 0) chk("snap_latency", 32'(cyc - t_acc + 1), 32'(r.lat));
          end
        end
      end
    end
  end

  // Behavioural slave: a register file of four counters behind the bus.
  initial begin : slave
    int d, idx;
    logic [31:0] a;
    logic w;
    @(posedge clk_i); #1;
    forever begin
      if (rst_ni && req_o) begin
        a = add_o;
        w = wen_o;
        idx = int'((a - BASE) >> 3) - 3;
        d = zero_wait ? 0 : int'($urandom_range(0, 3));
        if (w && idx == 1 && stall_dly >= 0) d = stall_dly;
        repeat (d) begin @(posedge clk_i); #1; end
        gnt_i = 1'b1;
        if (w && bogus) begin
          r_valid_i = 1'b1;
          r_id_i    = IDW'(MYID);
          r_rdata_i = 32'hDEAD_0000 | 32'(idx);
        end
        @(posedge clk_i); #1;
        gnt_i = 1'b0;
        r_valid_i = 1'b0;
        if (w && idx >= 0 && idx < 4) begin
          n_reads++;
          if (idx == drop_idx) begin
            t_drop_gnt = cyc;
          end else begin
            if (bad_id) begin
              r_valid_i = 1'b1;
              r_id_i    = IDW'(MYID + 1);
              r_rdata_i = ~ctr_val[idx];
              @(posedge clk_i); #1;
              r_valid_i = 1'b0;
            end
            d = zero_wait ? 0 : int'($urandom_range(0, 4));
            repeat (d) begin @(posedge clk_i); #1; end
            r_valid_i = 1'b1;
            r_id_i    = IDW'(MYID);
            r_rdata_i = ctr_val[idx];
            @(posedge clk_i); #1;
            r_valid_i = 1'b0;
          end
        end
      end else begin
        @(posedge clk_i); #1;
      end
    end
  end

  task automatic issue(input logic [1:0] op);
    int n;
    logic rdy;
    cmd_op_i = op;
    cmd_valid_i = 1'b1;
    n = 0;
    do begin
      rdy = cmd_ready_o;
      @(posedge clk_i);
      n++;
    end while (!rdy && n < 200);
    #1;
    cmd_valid_i = 1'b0;
    t_acc = cyc;
    if (!rdy) note_fail("cmd_accept_timeout", 32'(n));
  endtask

  task automatic do_write(input logic [1:0] op);
    exp_bus.push_back('{BASE + 32'(op) * 32'd8, 1'b0});
    issue(op);
  endtask

  // drop >= 0: that read never gets a response; expect_err picks timeout vs reset.
  task automatic snapshot(input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2,
                          input logic [31:0] c3, input int lat, input int drop, input bit expect_err);
    res_t r;
    ctr_val[0] = c0; ctr_val[1] = c1; ctr_val[2] = c2; ctr_val[3] = c3;
    drop_idx = drop;
    for (int i = 0; i < 4; i++)
      if (drop < 0 || i <= drop) exp_bus.push_back('{BASE + 32'((3 + i) * 8), 1'b1});
    r.lat = lat;
    if (drop >= 0) begin
      r.is_err = 1'b1;
      r.v = last_snap;
    end else begin
      r.is_err = 1'b0;
      r.v = {c3, c2, c1, c0};
    end
    if (drop < 0 || expect_err) exp_res.push_back(r);
    issue(CMD_SNAPSHOT);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(exp_bus.size() == 0 && exp_res.size() == 0 && cmd_ready_o) && n < 400) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 400) begin
      note_fail("drain_timeout", 32'(exp_bus.size() + exp_res.size()));
      exp_bus.delete();
      exp_res.delete();
    end
    drop_idx = -1;
  endtask

  initial begin : main
    int base_reads, n;
    logic [1:0] op;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_wen", 32'(wen_o), 32'd1);
    chk("rst_add", add_o, BASE);
    chk("rst_snap_cycle", snap_cycle_o, 32'd0);
    chk("rst_snap_stall", snap_stall_o, 32'd0);
    chk("rst_snap_imiss", snap_imiss_o, 32'd0);
    chk("rst_snap_dmiss", snap_dmiss_o, 32'd0);
    chk("rst_snap_valid", 32'(snap_valid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Zero-wait start: done after the request cycle.
    do_write(CMD_START);
    @(posedge clk_i); #1;
    chk("start_ready_again", 32'(cmd_ready_o), 32'd1);
    chk("start_bus_done", 32'(exp_bus.size()), 32'd0);
    do_write(CMD_CLEAR); wait_done();
    do_write(CMD_STOP);  wait_done();

    snapshot(32'd100, 32'd20, 32'd3, 32'd4, 9, -1, 1'b0);
    wait_done();

    zero_wait = 1'b0;
    stall_dly = 3;
    snapshot($urandom, $urandom, $urandom, $urandom, -1, -1, 1'b0);
    wait_done();
    stall_dly = -1;

    bad_id = 1'b1;
    bogus  = 1'b1;
    snapshot($urandom, $urandom, $urandom, $urandom, -1, -1, 1'b0);
    wait_done();

    for (int i = 0; i < 14; i++) begin
      zero_wait = 1'($urandom_range(0, 1));
      bad_id    = 1'($urandom_range(0, 1));
      bogus     = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      if (op == CMD_SNAPSHOT)
        snapshot($urandom, $urandom, $urandom, $urandom,
                 (zero_wait && !bad_id) ? 9 : -1, -1, 1'b0);
      else
        do_write(op);
      wait_done();
    end

    // No response to the imiss read; a busy-time command must be ignored.
    zero_wait = 1'b0; bad_id = 1'b0; bogus = 1'b0;
    snapshot($urandom, $urandom, $urandom, $urandom, -1, 2, 1'b1);
    cmd_op_i = CMD_START;
    cmd_valid_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    wait_done();

    zero_wait = 1'b1;
    snapshot($urandom, $urandom, $urandom, $urandom, 9, -1, 1'b0);
    wait_done();

    // Reset while waiting on the dmiss response.
    zero_wait = 1'b0;
    base_reads = n_reads;
    snapshot($urandom, $urandom, $urandom, $urandom, -1, 3, 1'b0);
    n = 0;
    while (n_reads < base_reads + 4 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 200) note_fail("dmiss_grant_timeout", 32'(n_reads - base_reads));
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    chk("midrst_req", 32'(req_o), 32'd0);
    chk("midrst_snap_cycle", snap_cycle_o, 32'd0);
    chk("midrst_snap_stall", snap_stall_o, 32'd0);
    chk("midrst_snap_imiss", snap_imiss_o, 32'd0);
    chk("midrst_snap_dmiss", snap_dmiss_o, 32'd0);
    exp_bus.delete();
    exp_res.delete();
    last_snap = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    drop_idx = -1;
    repeat (20) @(posedge clk_i);
    #1;
    chk("midrst_idle", 32'(cmd_ready_o), 32'd1);

    zero_wait = 1'b1;
    snapshot($urandom, $urandom, $urandom, $urandom, 9, -1, 1'b0);
    wait_done();

    repeat (3) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
